// File: rtl/tank_pkg.sv
// Shared tank-game definitions: grid geometry, keycodes, direction and
// shell-state encodings, plus small helpers for tile stepping.
package tank_pkg;

  localparam int GRID_W   = 20;
  localparam int GRID_H   = 15;
  localparam int MAP_SIZE = 300;

  // WASD player keycodes
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  // Arrow player keycodes
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, COOLDOWN = 2'd2} shell_state_t;

  function automatic int dir_dx(dir_t d);
    case (d)
      LEFT:    return -1;
      RIGHT:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int dir_dy(dir_t d);
    case (d)
      UP:      return -1;
      DOWN:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic dir_t dir_reverse(dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  function automatic logic in_grid(int x, int y);
    return (x >= 0) && (x < GRID_W) && (y >= 0) && (y < GRID_H);
  endfunction

endpackage

// File: rtl/shell_ctrl_if.sv
// Game-side bus of the shell controller. There is no backpressure anywhere:
// the inputs are sampled every frame, ShellActive qualifies ShellX/ShellY
// as a visible shell, and Hit is a single-frame strobe with no ready/ack.
// state_dbg exposes the controller FSM state for observation.
interface shell_ctrl_if;
  import tank_pkg::*;

  logic       player;
  logic [7:0] keycode;
  int         TankX;
  int         TankY;
  int         EnemyX;
  int         EnemyY;
  int         map [MAP_SIZE];

  logic       ShellActive;
  int         ShellX;
  int         ShellY;
  logic       Hit;
  logic [1:0] Facing;
  logic [1:0] state_dbg;

  modport master (
    output player, keycode, TankX, TankY, EnemyX, EnemyY, map,
    input  ShellActive, ShellX, ShellY, Hit, Facing, state_dbg
  );

  modport slave (
    input  player, keycode, TankX, TankY, EnemyX, EnemyY, map,
    output ShellActive, ShellX, ShellY, Hit, Facing, state_dbg
  );
endinterface

// File: rtl/shell_key_decode.sv
// Combinational keycode decoder: direction key and fire key for either player.
module shell_key_decode
  import tank_pkg::*;
(
  input  logic       player,
  input  logic [7:0] keycode,
  output logic       dir_valid,
  output dir_t       dir,
  output logic       fire_key
);

  // Map the keycode onto a direction and fire flag for the selected player
  always_comb begin
    dir_valid = 1'b1;
    dir       = UP;
    fire_key  = 1'b0;
    if (player) begin
      case (keycode)
        KEY_A:   dir = LEFT;
        KEY_D:   dir = RIGHT;
        KEY_S:   dir = DOWN;
        KEY_W:   dir = UP;
        default: dir_valid = 1'b0;
      endcase
      fire_key = (keycode == KEY_SPACE);
    end else begin
      case (keycode)
        KEY_LEFT:  dir = LEFT;
        KEY_RIGHT: dir = RIGHT;
        KEY_DOWN:  dir = DOWN;
        KEY_UP:    dir = UP;
        default:   dir_valid = 1'b0;
      endcase
      fire_key = (keycode == KEY_ENTER);
    end
  end

endmodule

// File: rtl/shell_ctrl.sv
// Per-player shell controller: tracks facing, launches one shell per fire
// press and steps it tile by tile until wall, grid edge, range or enemy.
// Optional build macro SHELL_BOUNCE_EN: first wall/edge collision reverses
// the shell instead of expiring it.
module shell_ctrl
  import tank_pkg::*;
#(
  parameter int SHELL_PERIOD    = 2,
  parameter int MAX_RANGE       = 10,
  parameter int COOLDOWN_FRAMES = 30
) (
  input logic         frame_clk,
  input logic         Reset,
  shell_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_FLY      = FLY;
  localparam logic [1:0] ST_COOLDOWN = COOLDOWN;

  logic       key_dir_valid;
  dir_t       key_dir;
  logic       fire_key;

  logic [1:0] state_q, state_d;
  dir_t       facing_q, facing_d;
  dir_t       dir_q, dir_d;
  int         shell_x_q, shell_x_d;
  int         shell_y_q, shell_y_d;
  logic       active_q, active_d;
  logic       hit_q, hit_d;
  int         step_q, step_d;
  int         range_q, range_d;
  int         cool_q, cool_d;
  logic       fire_prev_q, fire_prev_d;
  logic       bounced_q, bounced_d;

  int         spawn_x, spawn_y, next_x, next_y;
  logic [8:0] spawn_idx, next_idx;
  logic       spawn_open, next_open, fire_edge, go_cool;

  shell_key_decode u_key_decode (
    .player    (bus.player),
    .keycode   (bus.keycode),
    .dir_valid (key_dir_valid),
    .dir       (key_dir),
    .fire_key  (fire_key)
  );

  // Candidate tiles; the map is only consulted once the tile is known in-grid
  always_comb begin
    spawn_x    = bus.TankX + dir_dx(facing_q);
    spawn_y    = bus.TankY + dir_dy(facing_q);
    next_x     = shell_x_q + dir_dx(dir_q);
    next_y     = shell_y_q + dir_dy(dir_q);
    spawn_idx  = 9'(spawn_y * GRID_W + spawn_x);
    next_idx   = 9'(next_y * GRID_W + next_x);
    spawn_open = 1'b0;
    next_open  = 1'b0;
    if (in_grid(spawn_x, spawn_y)) spawn_open = (bus.map[spawn_idx] == 0);
    if (in_grid(next_x, next_y))   next_open  = (bus.map[next_idx] == 0);
    fire_edge  = fire_key && !fire_prev_q;
  end

  // Next-state logic for facing, launch, flight and cooldown
  always_comb begin
    state_d     = state_q;
    facing_d    = facing_q;
    dir_d       = dir_q;
    shell_x_d   = shell_x_q;
    shell_y_d   = shell_y_q;
    active_d    = active_q;
    hit_d       = 1'b0;
    step_d      = step_q;
    range_d     = range_q;
    cool_d      = cool_q;
    bounced_d   = bounced_q;
    fire_prev_d = fire_key;
    go_cool     = 1'b0;
    if (key_dir_valid) facing_d = key_dir;
    case (state_q)
      ST_IDLE: begin
        if (fire_edge) begin
          if (!spawn_open) begin
            go_cool = 1'b1;
          end else if (spawn_x == bus.EnemyX && spawn_y == bus.EnemyY) begin
            hit_d   = 1'b1;
            go_cool = 1'b1;
          end else begin
            shell_x_d = spawn_x;
            shell_y_d = spawn_y;
            dir_d     = facing_q;
            active_d  = 1'b1;
            range_d   = 1;
            step_d    = 0;
            bounced_d = 1'b0;
            state_d   = ST_FLY;
          end
        end
      end
      ST_FLY: begin
        if (shell_x_q == bus.EnemyX && shell_y_q == bus.EnemyY) begin
          // Enemy drove onto the shell
          hit_d   = 1'b1;
          go_cool = 1'b1;
        end else if (step_q + 1 >= SHELL_PERIOD) begin
          step_d = 0;
          if (range_q >= MAX_RANGE) begin
            go_cool = 1'b1;
          end else if (!next_open) begin
`ifdef SHELL_BOUNCE_EN
            if (!bounced_q) begin
              dir_d     = dir_reverse(dir_q);
              bounced_d = 1'b1;
            end else begin
              go_cool = 1'b1;
            end
`else
            go_cool = 1'b1;
`endif
          end else begin
            shell_x_d = next_x;
            shell_y_d = next_y;
            range_d   = range_q + 1;
            if (next_x == bus.EnemyX && next_y == bus.EnemyY) begin
              hit_d   = 1'b1;
              go_cool = 1'b1;
            end
          end
        end else begin
          step_d = step_q + 1;
        end
      end
      ST_COOLDOWN: begin
        if (cool_q >= COOLDOWN_FRAMES - 1) begin
          cool_d  = 0;
          state_d = ST_IDLE;
        end else begin
          cool_d = cool_q + 1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_cool) begin
      active_d = 1'b0;
      cool_d   = 0;
      state_d  = ST_COOLDOWN;
    end
  end

  // State registers; reset snaps the shell back onto the tank and drops it
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      facing_q    <= bus.player ? UP : DOWN;
      dir_q       <= UP;
      shell_x_q   <= bus.TankX;
      shell_y_q   <= bus.TankY;
      active_q    <= 1'b0;
      hit_q       <= 1'b0;
      step_q      <= 0;
      range_q     <= 0;
      cool_q      <= 0;
      fire_prev_q <= 1'b0;
      bounced_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      facing_q    <= facing_d;
      dir_q       <= dir_d;
      shell_x_q   <= shell_x_d;
      shell_y_q   <= shell_y_d;
      active_q    <= active_d;
      hit_q       <= hit_d;
      step_q      <= step_d;
      range_q     <= range_d;
      cool_q      <= cool_d;
      fire_prev_q <= fire_prev_d;
      bounced_q   <= bounced_d;
    end
  end

  assign bus.ShellActive = active_q;
  assign bus.ShellX      = shell_x_q;
  assign bus.ShellY      = shell_y_q;
  assign bus.Hit         = hit_q;
  assign bus.Facing      = facing_q;
  assign bus.state_dbg   = state_q;

endmodule
